// File: rtl/sr_drv_pkg.sv
// Shared types for the SR latch driver: FSM state encoding and command op values.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  localparam logic OP_RESET = 1'b0;
  localparam logic OP_SET   = 1'b1;

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer with asynchronous reset to 0.
// Ports: clk, rst (async, active high), d (asynchronous input), q (synchronized output).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Drives the active-low set/reset inputs of an external NAND SR latch from a
// valid/ready command port: one fixed-width pulse, a settle window, and an
// optional synchronized readback of q/qb (enabled by macro SR_DRV_READBACK_EN).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid/op    command request; op 1 = set, 0 = reset
//   cmd_ready       high only while idle
//   set_n, reset_n  registered active-low latch drives
//   q_in, qb_in     latch outputs (asynchronous; unused without readback)
//   busy            inverse of cmd_ready
//   done, err       one-cycle completion / readback-failure pulses
//   state_q         last successfully written latch value
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_op,
  output logic cmd_ready,
  output logic set_n,
  output logic reset_n,
  input  logic q_in,
  input  logic qb_in,
  output logic busy,
  output logic done,
  output logic err,
  output logic state_q
);

  state_e           state_r, state_d;
  logic [CNT_W-1:0] cnt_r, cnt_d;
  logic             op_r, op_d;
  logic             done_d, err_d, state_q_d;
  logic             set_n_d, reset_n_d;

`ifdef SR_DRV_READBACK_EN
  logic q_s, qb_s;
  logic match;

  sync2 u_sync_q  (.clk(clk), .rst(rst), .d(q_in),  .q(q_s));
  sync2 u_sync_qb (.clk(clk), .rst(rst), .d(qb_in), .q(qb_s));

  // An invalid pair (q_s == qb_s) can never satisfy both terms.
  assign match = (q_s == op_r) && (qb_s == ~op_r);
`else
  logic             unused_rb;
  logic [CNT_W-1:0] unused_timeout;
  assign unused_rb      = q_in ^ qb_in;
  assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      op_r      <= OP_RESET;
      set_n     <= 1'b1;
      reset_n   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      state_q   <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_d;
      cnt_r     <= cnt_d;
      op_r      <= op_d;
      set_n     <= set_n_d;
      reset_n   <= reset_n_d;
      done      <= done_d;
      err       <= err_d;
      state_q   <= state_q_d;
      cmd_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_r;
    cnt_d     = cnt_r;
    op_d      = op_r;
    done_d    = 1'b0;
    err_d     = 1'b0;
    state_q_d = state_q;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_r == '0) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_r - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_r == '0) begin
`ifdef SR_DRV_READBACK_EN
          cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
          state_d = ST_CHECK;
`else
          done_d    = 1'b1;
          state_q_d = op_r;
          state_d   = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_r - CNT_W'(1);
        end
      end
`ifdef SR_DRV_READBACK_EN
      ST_CHECK: begin
        if (match) begin
          done_d    = 1'b1;
          state_q_d = op_r;
          state_d   = ST_IDLE;
        end else if (cnt_r == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_r - CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Only PULSE drives a line, and only one, so both can never be low together.
    set_n_d   = ~((state_d == ST_PULSE) && (op_d == OP_SET));
    reset_n_d = ~((state_d == ST_PULSE) && (op_d == OP_RESET));
  end

endmodule
